// File: rtl/switch_debouncer.sv
// Multi-bit switch conditioner: 2-flop synchronizer followed by a per-bit
// stability counter, with registered debounced level and rise/fall strobes.
module switch_debouncer #(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 16,
    parameter int STABLE_COUNT = 50000
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall
);

    // Last count value before a commit; STABLE_COUNT itself may not fit in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d = D;
        sync2_d = sync1_q;
        q_d     = q_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Any cycle where the synchronized input agrees with Q restarts the count.
            if (sync2_q[i] != q_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    q_d[i]    = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            q_q     <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Q    = q_q;
    assign Rise = rise_q;
    assign Fall = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random bouncing input,
// compared every cycle against a run-length reference model.
module tb_switch_debouncer;

    logic       Clk = 1'b0;
    logic       Resetn;
    logic [7:0] d_a;
    logic [7:0] q_a, rise_a, fall_a;
    logic [0:0] d_b;
    logic [0:0] q_b, rise_b, fall_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    switch_debouncer #(.WIDTH(8), .CNT_W(16), .STABLE_COUNT(4)) u_dut_a (
        .Clk(Clk), .Resetn(Resetn), .D(d_a), .Q(q_a), .Rise(rise_a), .Fall(fall_a)
    );

    switch_debouncer #(.WIDTH(1), .CNT_W(3), .STABLE_COUNT(8)) u_dut_b (
        .Clk(Clk), .Resetn(Resetn), .D(d_b), .Q(q_b), .Rise(rise_b), .Fall(fall_b)
    );

    // Reference model: input seen two edges late; Q flips once the delayed input
    // has disagreed with Q for sc consecutive edges.
    logic [7:0] m_s1 [2];
    logic [7:0] m_s2 [2];
    logic [7:0] m_q  [2];
    logic [7:0] m_r  [2];
    logic [7:0] m_f  [2];
    int         m_run [2][8];

    task automatic model_step(input int n, input logic [7:0] d, input logic rstn,
                              input int sc, input int w);
        if (!rstn) begin
            m_s1[n] = '0; m_s2[n] = '0; m_q[n] = '0; m_r[n] = '0; m_f[n] = '0;
            for (int i = 0; i < 8; i++) m_run[n][i] = 0;
        end else begin
            m_r[n] = '0;
            m_f[n] = '0;
            for (int i = 0; i < w; i++) begin
                if (m_s2[n][i] == m_q[n][i]) begin
                    m_run[n][i] = 0;
                end else begin
                    m_run[n][i] = m_run[n][i] + 1;
                    if (m_run[n][i] >= sc) begin
                        m_q[n][i]   = m_s2[n][i];
                        m_run[n][i] = 0;
                        if (m_q[n][i]) m_r[n][i] = 1'b1;
                        else           m_f[n][i] = 1'b1;
                    end
                end
            end
            m_s2[n] = m_s1[n];
            m_s1[n] = d;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, step the model on the rising edge,
    // then compare everything 1 time unit later.
    task automatic cyc(input logic [7:0] da, input logic db, input logic rstn);
        @(negedge Clk);
        d_a    = da;
        d_b    = db;
        Resetn = rstn;
        @(posedge Clk);
        model_step(0, da, rstn, 4, 8);
        model_step(1, {7'b0, db}, rstn, 8, 1);
        #1;
        chk("q_a",    {24'b0, q_a},    {24'b0, m_q[0]});
        chk("rise_a", {24'b0, rise_a}, {24'b0, m_r[0]});
        chk("fall_a", {24'b0, fall_a}, {24'b0, m_f[0]});
        chk("both_a", {24'b0, rise_a & fall_a}, 32'h0);
        chk("q_b",    {31'b0, q_b},    {31'b0, m_q[1][0]});
        chk("rise_b", {31'b0, rise_b}, {31'b0, m_r[1][0]});
        chk("fall_b", {31'b0, fall_b}, {31'b0, m_f[1][0]});
    endtask

    logic [7:0] rd;
    logic       rb;

    initial begin
        d_a = '0; d_b = '0; Resetn = 1'b0;
        for (int n = 0; n < 2; n++) model_step(n, 8'h00, 1'b0, 1, 8);

        // Reset held with all switches high
        for (int e = 0; e < 3; e++) begin
            cyc(8'hFF, 1'b0, 1'b0);
            chk("rst_q", {24'b0, q_a}, 32'h0);
            chk("rst_rise", {24'b0, rise_a}, 32'h0);
        end
        for (int e = 0; e < 7; e++) begin
            cyc(8'hFF, 1'b0, 1'b1);
            chk("rel_q", {24'b0, q_a}, (e >= 5) ? 32'hFF : 32'h0);
            chk("rel_rise", {24'b0, rise_a}, (e == 5) ? 32'hFF : 32'h0);
        end

        // All fall, then clean edge on bit 0
        for (int e = 0; e < 7; e++) begin
            cyc(8'h00, 1'b0, 1'b1);
            chk("all_fall", {24'b0, fall_a}, (e == 5) ? 32'hFF : 32'h0);
        end
        for (int e = 0; e < 7; e++) begin
            cyc(8'h01, 1'b0, 1'b1);
            chk("edge_q0", {31'b0, q_a[0]}, (e >= 5) ? 32'h1 : 32'h0);
            chk("edge_rise0", {31'b0, rise_a[0]}, (e == 5) ? 32'h1 : 32'h0);
        end
        for (int e = 0; e < 7; e++) begin
            cyc(8'h00, 1'b0, 1'b1);
            chk("edge_fall0", {31'b0, fall_a[0]}, (e == 5) ? 32'h1 : 32'h0);
        end

        // Bounce on bit 3, then steady high
        for (int e = 0; e < 4; e++) begin
            cyc((e % 2 == 0) ? 8'h08 : 8'h00, 1'b0, 1'b1);
            chk("bounce_rise", {24'b0, rise_a}, 32'h0);
        end
        for (int e = 0; e < 8; e++) begin
            cyc(8'h08, 1'b0, 1'b1);
            chk("bounce_q3", {31'b0, q_a[3]}, (e >= 5) ? 32'h1 : 32'h0);
            chk("bounce_rise3", {31'b0, rise_a[3]}, (e == 5) ? 32'h1 : 32'h0);
        end
        for (int e = 0; e < 7; e++) cyc(8'h00, 1'b0, 1'b1);

        // Independence: bit 1 at edge 0, bit 6 at edge 2
        for (int e = 0; e < 9; e++) begin
            cyc((e >= 2) ? 8'h42 : 8'h02, 1'b0, 1'b1);
            chk("indep_rise", {24'b0, rise_a},
                (e == 5) ? 32'h02 : ((e == 7) ? 32'h40 : 32'h0));
        end
        for (int e = 0; e < 7; e++) cyc(8'h00, 1'b0, 1'b1);

        // Reset mid-count on bit 2
        for (int e = 0; e < 3; e++) cyc(8'h04, 1'b0, 1'b1);
        cyc(8'h04, 1'b0, 1'b0);
        chk("mid_q2", {31'b0, q_a[2]}, 32'h0);
        for (int e = 0; e < 8; e++) begin
            cyc(8'h04, 1'b0, 1'b1);
            chk("mid_q2_after", {31'b0, q_a[2]}, (e >= 5) ? 32'h1 : 32'h0);
            chk("mid_rise2", {31'b0, rise_a[2]}, (e == 5) ? 32'h1 : 32'h0);
        end

        // Full-range counter (CNT_W=3, STABLE_COUNT=8) clean step
        for (int e = 0; e < 12; e++) begin
            cyc(8'h04, 1'b1, 1'b1);
            chk("max_q", {31'b0, q_b}, (e >= 9) ? 32'h1 : 32'h0);
            chk("max_rise", {31'b0, rise_b}, (e == 9) ? 32'h1 : 32'h0);
            chk("max_fall", {31'b0, fall_b}, 32'h0);
        end

        // Random bouncing inputs with occasional reset
        rd = 8'h00;
        rb = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) rd[i] = ~rd[i];
            end
            if ($urandom_range(0, 9) == 0) rb = ~rb;
            cyc(rd, rb, ($urandom_range(0, 399) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
